instr_fetch_unit: RTL and testbench

- Producer side of the instruction path. Fetches 32-bit instruction words from memory and buffers them in a small prefetch FIFO.
- Presents the FIFO head to the control/decode block through a valid/ack handshake; ack is driven by instr_reg_WE.
- Flushes and re-targets on redirect, driven by pc_WE on branch/jump.
- Sits between the instruction-memory port and the decode block's instruction input.

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

    localparam int WORD_WIDTH            = 32;
    localparam int FETCH_DEPTH           = 4;
    localparam int FETCH_MAX_OUTSTANDING = 2;
    localparam logic [WORD_WIDTH-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] instr;
        logic [WORD_WIDTH-1:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
        return addr & ~WORD_WIDTH'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} entries; flush beats push and pop.
// Latency: push visible at dout the cycle after the write (registered storage).
// Backpressure: none internally; the caller must never push when full.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word reads, buffers responses, presents head to decode; FETCH_BYPASS_EN adds empty-FIFO bypass.
// Latency: response to instr_valid is 1 cycle (0 with FETCH_BYPASS_EN); redirect drains stale responses.
// Backpressure: issue stalls while outstanding + FIFO occupancy would exceed DEPTH; instr_ack pops the head.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    DEPTH           = FETCH_DEPTH,
    parameter int                    MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
    parameter logic [WORD_WIDTH-1:0] RESET_PC        = FETCH_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic [WORD_WIDTH-1:0] fetch_pc,
    output logic                  instr_valid,
    input  logic                  instr_ack,
    input  logic                  redirect,
    input  logic [WORD_WIDTH-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W:0]   DEPTH_L = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_L   = CNT_W'(MAX_OUTSTANDING);

    fetch_state_e state_q, state_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    fetch_entry_t          last_q, last_d;

    fetch_entry_t     head, rsp_entry, out_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic             accept, rsp_ok, rsp_kept, bypass_hit, bypass_take;
    logic [WORD_WIDTH-1:0] target_pc;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .din   (rsp_entry),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        target_pc = word_align(redirect_pc);
        accept    = mem_req && mem_ready;
        // A response with nothing outstanding is a protocol violation and is ignored.
        rsp_ok    = mem_rvalid && (outst_q != '0);
        rsp_kept  = rsp_ok && (drop_q == '0) && !redirect;
        rsp_entry = '{instr: mem_rdata, pc: rsp_pc_q};
`ifdef FETCH_BYPASS_EN
        bypass_hit  = fifo_empty && rsp_kept;
        bypass_take = bypass_hit && instr_ack;
`else
        bypass_hit  = 1'b0;
        bypass_take = 1'b0;
`endif
        fifo_push   = rsp_kept && !bypass_take;
        fifo_pop    = !fifo_empty && instr_ack && !redirect;
        instr_valid = !fifo_empty || bypass_hit;
        if (!fifo_empty)     out_entry = head;
        else if (bypass_hit) out_entry = rsp_entry;
        else                 out_entry = last_q;
        last_d = instr_valid ? out_entry : last_q;

        outst_d  = outst_q + CNT_W'(accept) - CNT_W'(rsp_ok);
        addr_d   = redirect ? target_pc : (accept   ? addr_q + 32'd4   : addr_q);
        rsp_pc_d = redirect ? target_pc : (rsp_kept ? rsp_pc_q + 32'd4 : rsp_pc_q);
        // Everything still in flight at a redirect belongs to the old stream.
        if (redirect)                   drop_d = outst_d;
        else if (rsp_ok && drop_q != '0) drop_d = drop_q - CNT_W'(1);
        else                            drop_d = drop_q;
    end

    assign instruction = out_entry.instr;
    assign fetch_pc    = out_entry.pc;
    assign mem_addr    = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            addr_q   <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            last_q   <= '{instr: '0, pc: RESET_PC};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redirect && outst_d != '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (redirect) state_d = (outst_d != '0) ? ST_DRAIN : ST_RUN;
                else if (drop_d == '0) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        mem_req = !rst && (state_q == ST_RUN) && !redirect && (outst_q < MAX_L) &&
                  (({1'b0, fifo_count} + {1'b0, outst_q}) < DEPTH_L);
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst) !(mem_rvalid && outst_q == '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a request-ordered memory model and a fetch scoreboard.
// Latency: checks 1-cycle response-to-valid (0 with FETCH_BYPASS_EN).
// Backpressure: exercises ack stalls, mem_ready stalls and redirect drains.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic [31:0] fetch_pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .fetch_pc    (fetch_pc),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] cons_pc_log[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit resp_en  = 1'b1;
    int acc_cnt  = 0;
    int cons_cnt = 0;

    logic        s_req, s_valid, s_acc, s_cons;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample at negedge, update model/scoreboard.
    task automatic step();
        logic [63:0] e;
        if (resp_en && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = data_of(pend_q[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_valid = instr_valid;
        s_instr = instruction;
        s_pc    = fetch_pc;
        s_acc   = mem_req && mem_ready;
        s_cons  = instr_valid && instr_ack && !redirect;
        if (redirect) exp_q.delete();
        if (s_cons) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_instr", s_instr, e[63:32]);
                check("sb_pc", s_pc, e[31:0]);
            end
            cons_pc_log.push_back(s_pc);
            cons_cnt++;
        end
        if (s_acc) begin
            pend_q.push_back('{addr: s_addr, due: cyc + lat});
            exp_q.push_back({data_of(s_addr), s_addr});
            acc_log.push_back(s_addr);
            acc_cnt++;
        end
        if (mem_rvalid) void'(pend_q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        pend_q.delete();
        exp_q.delete();
        acc_log.delete();
        cons_pc_log.delete();
        acc_cnt  = 0;
        cons_cnt = 0;
        cyc      = 0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int c0;
        logic v10, v11;
        logic [31:0] i10, i11, p11;

        rst         = 1'b1;
        mem_ready   = 1'b1;
        instr_ack   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        #12;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_fetch_pc", fetch_pc, 32'h0);

        // Streaming: ready memory, 1-cycle latency, decoder always acks.
        do_reset();
        mem_ready = 1'b1; instr_ack = 1'b1; lat = 1; resp_en = 1'b1;
        repeat (12) step();
        check("t1_acc_count", 32'(acc_log.size() >= 4), 32'd1);
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("t1_req_addr", acc_log[i], 32'(4 * i));
        end
        check("t1_cons_count", 32'(cons_pc_log.size() >= 2), 32'd1);
        if (cons_pc_log.size() >= 2) begin
            check("t1_first_pc", cons_pc_log[0], 32'h0);
            check("t1_second_pc", cons_pc_log[1], 32'h4);
        end
        c0 = cons_cnt;
        repeat (10) step();
        check("t1_throughput", 32'(cons_cnt - c0), 32'd10);

        // Decoder stalled: FIFO fills to DEPTH, then one ack buys one request.
        do_reset();
        instr_ack = 1'b0;
        repeat (12) step();
        check("t2_accepts", 32'(acc_cnt), 32'd4);
        check("t2_req_low", 32'(s_req), 32'd0);
        check("t2_valid", 32'(s_valid), 32'd1);
        check("t2_head_pc", s_pc, 32'h0);
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        check("t2_one_consume", 32'(cons_cnt), 32'd1);
        a0 = acc_cnt;
        repeat (8) step();
        check("t2_one_more_req", 32'(acc_cnt - a0), 32'd1);
        check("t2_head_after", s_pc, 32'h4);

        // Memory not ready: address held while request pending.
        do_reset();
        instr_ack = 1'b1; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_req_held", 32'(s_req), 32'd1);
            check("t3_addr_held", s_addr, 32'h8);
        end
        check("t3_no_accept", 32'(acc_cnt), 32'd2);
        mem_ready = 1'b1;
        step();
        check("t3_accept", 32'(s_acc), 32'd1);
        check("t3_accept_addr", s_addr, 32'h8);
        repeat (8) step();

        // Redirect with two outstanding and a non-empty FIFO.
        do_reset();
        instr_ack = 1'b0; mem_ready = 1'b1; lat = 1; resp_en = 1'b1;
        repeat (3) step();
        resp_en = 1'b0;
        step();
        check("t4_setup_accepts", 32'(acc_cnt), 32'd4);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        check("t4_req_in_redirect", 32'(s_req), 32'd0);
        redirect = 1'b0; resp_en = 1'b1;
        check("t4_flushed", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4_drain_req", 32'(s_req), 32'd0);
            check("t4_drain_valid", 32'(s_valid), 32'd0);
        end
        step();
        check("t4_restart_req", 32'(s_acc), 32'd1);
        check("t4_restart_addr", s_addr, 32'h0000_0100);
        instr_ack = 1'b1;
        repeat (6) step();
        check("t4_delivered", 32'(cons_pc_log.size() >= 1), 32'd1);
        if (cons_pc_log.size() >= 1) check("t4_first_pc", cons_pc_log[0], 32'h0000_0100);

        // Redirect coinciding with ack and an arriving response.
        do_reset();
        instr_ack = 1'b0; lat = 1; resp_en = 1'b1;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200; instr_ack = 1'b1;
        step();
        check("t5_rvalid_seen", 32'(pend_q.size()), 32'd0);
        check("t5_ack_ignored", 32'(cons_cnt), 32'd0);
        redirect = 1'b0; instr_ack = 1'b0;
        check("t5_flushed", 32'(instr_valid), 32'd0);
        step();
        check("t5_req_after", 32'(s_req), 32'd1);
        check("t5_addr_after", s_addr, 32'h0000_0200);
        instr_ack = 1'b1;
        repeat (5) step();
        check("t5_delivered", 32'(cons_pc_log.size() >= 1), 32'd1);
        if (cons_pc_log.size() >= 1) check("t5_first_pc", cons_pc_log[0], 32'h0000_0200);

        // Response-to-valid latency with an empty FIFO, response in cycle 10.
        do_reset();
        instr_ack = 1'b0; lat = 1; resp_en = 1'b0;
        while (cyc < 10) step();
        check("t6_idle_valid", 32'(s_valid), 32'd0);
        resp_en = 1'b1;
        step();
        v10 = s_valid; i10 = s_instr;
        step();
        v11 = s_valid; i11 = s_instr; p11 = s_pc;
`ifdef FETCH_BYPASS_EN
        check("t6_valid_c10", 32'(v10), 32'd1);
        check("t6_instr_c10", i10, data_of(32'h0));
`else
        check("t6_valid_c10", 32'(v10), 32'd0);
`endif
        check("t6_valid_c11", 32'(v11), 32'd1);
        check("t6_instr_c11", i11, data_of(32'h0));
        check("t6_pc_c11", p11, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
